uart_wb_debug_master: RTL
=========================

// Module: uart_wb_debug_master
// PURPOSE
// Host-side debug initiator: receives 8N1 command frames from the FTDI UART, issues single 32-bit
// Wishbone read/write cycles as bus master, returns status (and read data) over UART TX.
// Sits on the SoC Wishbone interconnect as a second master next to the CPU, so a host can
// peek/poke memory and peripherals independently of firmware.
// PARAMETERS
// CLK_DIV     208  clock cycles per UART bit (24 MHz / 115200); legal range 16..65535
// WB_TIMEOUT  255  max cycles waiting for ack/err before the cycle is aborted as error; legal range 1..65535
// PORTS
// clock       in   1   system/Wishbone clock, all logic on rising edge
// reset_n     in   1   synchronous reset, active low
// uart_rx_i   in   1   UART receive line from host, asynchronous, idle high
// uart_tx_o   out  1   UART transmit line to host, idle high
// wb_adr_o    out  32  Wishbone address
// wb_dat_o    out  32  Wishbone write data
// wb_dat_i    in   32  Wishbone read data
// wb_sel_o    out  4   byte selects, always 4'hF during a cycle
// wb_we_o     out  1   write enable
// wb_cyc_o    out  1   cycle valid
// wb_stb_o    out  1   strobe, equal to wb_cyc_o
// wb_ack_i    in   1   slave acknowledge
// wb_err_i    in   1   slave error
// busy_o      out  1   high whenever the FSM is not in IDLE
// BEHAVIOUR
// Reset (reset_n low at a clock edge): uart_tx_o=1, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_sel_o=0,
//   wb_adr_o=wb_dat_o=0, busy_o=0, FSM=IDLE, RX/TX shifters idle. Reset mid-frame or mid-cycle
//   drops the cycle immediately and discards any byte in flight, with no response.
// UART RX: 2-flop synchronizer. A falling edge while idle starts a bit counter. The start bit is
//   re-sampled at CLK_DIV/2; if high, it is a glitch and RX returns to idle. Data bits are sampled
//   every CLK_DIV thereafter, LSB first. The stop bit is sampled; if it is 0 (framing error), the
//   byte is dropped and the frame FSM returns to IDLE.
// UART TX: 1 start bit, 8 data bits LSB first, 1 stop bit, each CLK_DIV cycles. The next byte is
//   loaded the cycle after the stop bit ends, so back-to-back bytes have no idle gap.
// Frame format, multi-byte fields MSB first:
//   'W'(0x57) A3 A2 A1 A0 D3 D2 D1 D0  -> write
//   'R'(0x52) A3 A2 A1 A0              -> read
// Any other byte received in IDLE is ignored (no response).
// FSM states:
//   IDLE: 0x57 or 0x52 -> ADDR, latching we=1 or we=0.
//   ADDR: collect 4 bytes into wb_adr_o -> DATA if write, else BUS.
//   DATA: collect 4 bytes into wb_dat_o -> BUS.
//   BUS: wb_cyc_o=wb_stb_o=1 and wb_sel_o=4'hF from the cycle after the last byte; timeout counter runs.
//     - ack (ack has priority if ack and err are seen in the same cycle): deassert cyc/stb the next
//       edge, latch wb_dat_i on reads, status=0x4B ('K').
//     - err, or the counter reaching WB_TIMEOUT: deassert cyc/stb, status=0x45 ('E').
//     - then -> RESP.
//   RESP: send the status byte. If it is 'K' and the command is a read, also send 4 read-data bytes,
//     MSB first. -> IDLE after the last stop bit.
// RX bytes arriving during BUS or RESP are discarded; the host must wait for the response.
// wb_adr_o/wb_dat_o hold their values after a cycle until overwritten by the next frame.
// TESTING
// 1. Write: RX 57 00 00 10 00 DE AD BE EF, slave acks after 3 cycles -> exactly one cycle with
//    adr=0x00001000, dat=0xDEADBEEF, we=1, sel=F; TX returns 4B.
// 2. Read: RX 52 80 00 00 04, slave returns 0x12345678 with ack -> TX returns 4B 12 34 56 78, with
//    back-to-back bytes and no idle gap.
// 3. Error and timeout: slave asserts err -> TX 45. A slave that never responds -> cyc drops after
//    exactly WB_TIMEOUT cycles, TX 45, and no data bytes even for a read.
// 4. Robustness: a 1-cycle low glitch on rx, an unknown byte 0x00, and a byte with stop bit=0 in
//    the middle of an address -> no bus cycle and no TX. A following valid frame executes correctly.
// 5. Reset mid-operation: reset_n pulsed low during BUS and during RESP -> cyc=0 and tx=1 on the next
//    edge, FSM in IDLE, and the next frame executes correctly.
// 6. Timing: CLK_DIV=16, bytes sent at ±3% baud error -> all frames decoded; the TX bit period
//    measures exactly 16 cycles.

Source files
------------

// File: rtl/uart_wb_debug_master.sv
// Host debug bridge: 8N1 UART command frames drive single 32-bit Wishbone cycles,
// and the status byte (plus read data) goes back over UART TX.
module uart_wb_debug_master #(
  parameter int unsigned CLK_DIV    = 208,
  parameter int unsigned WB_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        busy_o
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] TOUT_LAST = CW'(WB_TIMEOUT - 1);
  localparam logic [7:0]    CMD_WR    = 8'h57;
  localparam logic [7:0]    CMD_RD    = 8'h52;
  localparam logic [7:0]    ST_OK     = 8'h4B;
  localparam logic [7:0]    ST_ERR    = 8'h45;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

  state_t state, state_nxt;

  // UART receive path
  logic          rx_meta, rx_sync, rx_prev;
  logic          rx_busy;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_valid, rx_ferr;

  // UART transmit path
  logic          tx_busy;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_shift;
  logic          tx_end_c, tx_ready_c, tx_start_c;
  logic [7:0]    tx_byte_c;

  // Frame/bus bookkeeping
  logic          we_q, ok_q;
  logic [1:0]    byte_cnt;
  logic [2:0]    tx_idx;
  logic [2:0]    resp_len_c;
  logic [CW-1:0] tout_cnt;
  logic [31:0]   rdata_q;

  assign wb_stb_o = wb_cyc_o;

  // Start bit is confirmed at mid-bit; data and stop bits follow one bit period apart.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_busy  <= 1'b0;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_meta  <= uart_rx_i;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (!rx_busy) begin
        if (rx_prev && !rx_sync) begin
          rx_busy <= 1'b1;
          rx_cnt  <= '0;
          rx_bit  <= '0;
        end
      end else if (rx_bit == 4'd0) begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt <= '0;
          if (rx_sync) rx_busy <= 1'b0;
          else         rx_bit  <= 4'd1;
        end else begin
          rx_cnt <= rx_cnt + CW'(1);
        end
      end else if (rx_cnt == BIT_LAST) begin
        rx_cnt <= '0;
        if (rx_bit == 4'd9) begin
          rx_busy  <= 1'b0;
          rx_valid <= rx_sync;
          rx_ferr  <= !rx_sync;
        end else begin
          rx_shift <= {rx_sync, rx_shift[7:1]};
          rx_bit   <= rx_bit + 4'd1;
        end
      end else begin
        rx_cnt <= rx_cnt + CW'(1);
      end
    end
  end

  // The stop bit's final cycle doubles as a load slot so consecutive bytes abut.
  assign tx_end_c   = tx_busy && (tx_bit == 4'd9) && (tx_cnt == BIT_LAST);
  assign tx_ready_c = !tx_busy || tx_end_c;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tx_busy   <= 1'b0;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '1;
      uart_tx_o <= 1'b1;
    end else if (tx_start_c) begin
      tx_busy   <= 1'b1;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= {1'b1, tx_byte_c};
      uart_tx_o <= 1'b0;
    end else if (tx_busy) begin
      if (tx_cnt == BIT_LAST) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy   <= 1'b0;
          uart_tx_o <= 1'b1;
        end else begin
          uart_tx_o <= tx_shift[0];
          tx_shift  <= {1'b1, tx_shift[8:1]};
          tx_bit    <= tx_bit + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + CW'(1);
      end
    end
  end

  assign resp_len_c = (ok_q && !we_q) ? 3'd5 : 3'd1;

  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and response byte selection
  always_comb begin
    state_nxt  = state;
    tx_start_c = 1'b0;
    tx_byte_c  = ok_q ? ST_OK : ST_ERR;
    case (tx_idx)
      3'd1:    tx_byte_c = rdata_q[31:24];
      3'd2:    tx_byte_c = rdata_q[23:16];
      3'd3:    tx_byte_c = rdata_q[15:8];
      3'd4:    tx_byte_c = rdata_q[7:0];
      default: ;
    endcase
    case (state)
      S_IDLE: begin
        if (rx_valid && (rx_shift == CMD_WR || rx_shift == CMD_RD)) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        if (rx_ferr)                              state_nxt = S_IDLE;
        else if (rx_valid && byte_cnt == 2'd3)    state_nxt = we_q ? S_DATA : S_BUS;
      end
      S_DATA: begin
        if (rx_ferr)                              state_nxt = S_IDLE;
        else if (rx_valid && byte_cnt == 2'd3)    state_nxt = S_BUS;
      end
      S_BUS: begin
        if (wb_ack_i || wb_err_i || tout_cnt == TOUT_LAST) state_nxt = S_RESP;
      end
      S_RESP: begin
        if (tx_ready_c) begin
          if (tx_idx == resp_len_c) state_nxt  = S_IDLE;
          else                      tx_start_c = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus master registers; address/data hold after a cycle until the next frame shifts in.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      busy_o   <= 1'b0;
      we_q     <= 1'b0;
      ok_q     <= 1'b0;
      byte_cnt <= '0;
      tx_idx   <= '0;
      tout_cnt <= '0;
      rdata_q  <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
    end else begin
      busy_o <= (state_nxt != S_IDLE);
      if (state == S_IDLE && state_nxt == S_ADDR) begin
        we_q     <= (rx_shift == CMD_WR);
        byte_cnt <= '0;
      end
      if (rx_valid && state == S_ADDR) begin
        wb_adr_o <= {wb_adr_o[23:0], rx_shift};
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (rx_valid && state == S_DATA) begin
        wb_dat_o <= {wb_dat_o[23:0], rx_shift};
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (state != S_BUS && state_nxt == S_BUS) begin
        wb_cyc_o <= 1'b1;
        wb_sel_o <= 4'hF;
        wb_we_o  <= we_q;
        tout_cnt <= '0;
      end
      if (state == S_BUS) begin
        tout_cnt <= tout_cnt + CW'(1);
        if (state_nxt == S_RESP) begin
          wb_cyc_o <= 1'b0;
          wb_sel_o <= '0;
          wb_we_o  <= 1'b0;
          ok_q     <= wb_ack_i;
          tx_idx   <= '0;
          if (wb_ack_i && !we_q) rdata_q <= wb_dat_i;
        end
      end
      if (tx_start_c) tx_idx <= tx_idx + 3'd1;
    end
  end

endmodule
